// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester channels and the data-memory
// control bus around dmem_arbiter.
//   req0_*/rsp0_*  CPU load/store path (command in, response out)
//   req1_*/rsp1_*  debug/loader port   (command in, response out)
//   mem_*          strobes, address and data to/from the single-port memory
// Modports:
//   slave  - the arbiter: takes commands and read data, drives ready,
//            responses and memory strobes.
//   master - the environment around it: requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic              rsp0_err;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic              rsp1_err;
  logic [DATA_W-1:0] rsp1_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
    output mem_address, mem_write, mem_read, mem_wdata
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
    input  mem_address, mem_write, mem_read, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer in front of the
// single-port data memory (posedge write, negedge read).
// Ports:
//   clock  system clock, all state changes on posedge
//   reset  asynchronous, active-high
//   bus    dmem_arbiter_if.slave - two requester channels and memory bus
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready driven from arbitration; handshake latches the command
// ACCESS | one-cycle memory strobe for the latched command, then respond
module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp0_err_q, rsp0_err_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic              rsp1_err_q, rsp1_err_d;
  logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic              grant0, grant1;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = bus.req0_valid && (!bus.req1_valid ||  last_grant_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
  end

  always_comb begin
    sel_write = grant1 ? bus.req1_write : bus.req0_write;
    sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp0_valid_d = 1'b0;
    rsp0_err_d   = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_valid_d = 1'b0;
    rsp1_err_d   = 1'b0;
    rsp1_rdata_d = rsp1_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          gnt_d        = grant1;
          last_grant_d = grant1;
          wr_d         = sel_write;
          if (sel_addr[1:0] != 2'b00) begin
            // Rejected without a memory cycle; answer directly from IDLE.
            rsp0_valid_d = grant0;
            rsp0_err_d   = grant0;
            rsp1_valid_d = grant1;
            rsp1_err_d   = grant1;
          end else begin
            // Address/data only move for real accesses so the memory bus
            // keeps showing the last access while idle.
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (gnt_q) begin
          rsp1_valid_d = 1'b1;
          if (!wr_q) rsp1_rdata_d = bus.mem_rdata;
        end else begin
          rsp0_valid_d = 1'b1;
          if (!wr_q) rsp0_rdata_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_err   = rsp0_err_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_err   = rsp1_err_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;

  // Strobes decode straight from state so an async reset mid-ACCESS
  // removes them before the committing edge.
  assign bus.mem_write   = (state_q == ACCESS) &&  wr_q;
  assign bus.mem_read    = (state_q == ACCESS) && !wr_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// single-port memory (posedge write, negedge read).
module tb_dmem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [DW-1:0] mem [0:31];
  always @(posedge clock) if (bus.mem_write) mem[bus.mem_address[6:2]] <= bus.mem_wdata;
  always @(negedge clock) if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_address[6:2]];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv0(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0_valid = v;
    bus.req0_write = w;
    bus.req0_addr  = a;
    bus.req0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req1_valid = v;
    bus.req1_write = w;
    bus.req1_addr  = a;
    bus.req1_wdata = d;
  endtask

  task automatic store0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drv0(1'b1, 1'b1, a, d);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_rsp0v", bus.rsp0_valid, 0);
    chk("rst_rsp1v", bus.rsp1_valid, 0);
    chk("rst_mw", bus.mem_write, 0);
    chk("rst_mr", bus.mem_read, 0);
    chk("rst_maddr", bus.mem_address, 0);
    chk("rst_rdata0", bus.rsp0_rdata, 0);
    reset = 1'b0;

    // store then load through requester 0
    drv0(1'b1, 1'b1, 7'h08, 32'hDEADBEEF);
    #1;
    chk("t1_ready0", bus.req0_ready, 1);
    chk("t1_ready1", bus.req1_ready, 0);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    chk("t1_mw", bus.mem_write, 1);
    chk("t1_mr", bus.mem_read, 0);
    chk("t1_maddr", bus.mem_address, 32'h08);
    chk("t1_mwdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("t1_rsp_early", bus.rsp0_valid, 0);
    tick();
    chk("t1_mw_off", bus.mem_write, 0);
    chk("t1_st_rspv", bus.rsp0_valid, 1);
    chk("t1_st_err", bus.rsp0_err, 0);
    drv0(1'b1, 1'b0, 7'h08, '0);
    #1;
    chk("t1_ld_ready", bus.req0_ready, 1);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    chk("t1_ld_mr", bus.mem_read, 1);
    chk("t1_ld_mw", bus.mem_write, 0);
    chk("t1_ld_rsp_early", bus.rsp0_valid, 0);
    tick();
    chk("t1_ld_rspv", bus.rsp0_valid, 1);
    chk("t1_ld_err", bus.rsp0_err, 0);
    chk("t1_ld_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
    tick();
    chk("t1_rsp_done", bus.rsp0_valid, 0);

    store0(7'h04, 32'h11111111);
    store0(7'h0C, 32'h22222222);
    store0(7'h10, 32'h0BADF00D);

    // both requesters loading continuously: alternate, starting with 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv0(1'b1, 1'b0, 7'h04, '0);
    drv1(1'b1, 1'b0, 7'h0C, '0);
    #1;
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = k[0];
      chk("t2_ready0", bus.req0_ready, (g == 1'b0));
      chk("t2_ready1", bus.req1_ready, (g == 1'b1));
      chk("t2_rsp0v", bus.rsp0_valid, (k > 0 && g == 1'b1));
      chk("t2_rsp1v", bus.rsp1_valid, (k > 0 && g == 1'b0));
      if (k > 0 && g == 1'b1) chk("t2_rdata0", bus.rsp0_rdata, 32'h11111111);
      if (k > 0 && g == 1'b0) chk("t2_rdata1", bus.rsp1_rdata, 32'h22222222);
      tick();
      chk("t2_acc_ready0", bus.req0_ready, 0);
      chk("t2_acc_ready1", bus.req1_ready, 0);
      chk("t2_acc_mr", bus.mem_read, 1);
      chk("t2_acc_maddr", bus.mem_address, g ? 32'h0C : 32'h04);
      tick();
    end
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    #1;
    chk("t2_last_rsp1v", bus.rsp1_valid, 1);
    chk("t2_last_rdata1", bus.rsp1_rdata, 32'h22222222);
    tick();
    chk("t2_quiet", bus.rsp0_valid, 0);

    // misaligned load on requester 1
    drv1(1'b1, 1'b0, 7'h05, '0);
    #1;
    chk("t3_ready1", bus.req1_ready, 1);
    tick();
    drv1(1'b0, 1'b0, '0, '0);
    chk("t3_mr", bus.mem_read, 0);
    chk("t3_mw", bus.mem_write, 0);
    chk("t3_rspv", bus.rsp1_valid, 1);
    chk("t3_err", bus.rsp1_err, 1);
    chk("t3_rdata_held", bus.rsp1_rdata, 32'h22222222);
    tick();
    chk("t3_rsp_done", bus.rsp1_valid, 0);
    chk("t3_mr_after", bus.mem_read, 0);

    // reset during a store's ACCESS cycle
    drv0(1'b1, 1'b1, 7'h10, 32'hA5A5A5A5);
    #1;
    chk("t4_ready0", bus.req0_ready, 1);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    chk("t4_mw", bus.mem_write, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t4_mw_drop", bus.mem_write, 0);
    chk("t4_mr_drop", bus.mem_read, 0);
    tick();
    chk("t4_no_rsp_rst", bus.rsp0_valid, 0);
    reset = 1'b0;
    tick();
    chk("t4_no_rsp", bus.rsp0_valid, 0);
    drv0(1'b1, 1'b0, 7'h10, '0);
    #1;
    chk("t4_ld_ready", bus.req0_ready, 1);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    tick();
    chk("t4_ld_rspv", bus.rsp0_valid, 1);
    chk("t4_ld_rdata", bus.rsp0_rdata, 32'h0BADF00D);

    // req0 shows valid for one cycle while req1 wins, then withdraws
    drv0(1'b1, 1'b0, 7'h04, '0);
    drv1(1'b1, 1'b0, 7'h0C, '0);
    #1;
    chk("t5_ready1", bus.req1_ready, 1);
    chk("t5_ready0", bus.req0_ready, 0);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    chk("t5_mr", bus.mem_read, 1);
    chk("t5_maddr", bus.mem_address, 32'h0C);
    tick();
    chk("t5_rsp1v", bus.rsp1_valid, 1);
    chk("t5_rdata1", bus.rsp1_rdata, 32'h22222222);
    chk("t5_rsp0v", bus.rsp0_valid, 0);
    chk("t5_mr_off", bus.mem_read, 0);
    tick();
    chk("t5_rsp0v_late", bus.rsp0_valid, 0);
    chk("t5_mr_late", bus.mem_read, 0);

    // req0 granted in the same cycle as rsp1's pulse
    drv1(1'b1, 1'b0, 7'h04, '0);
    #1;
    chk("t6_ready1", bus.req1_ready, 1);
    tick();
    drv1(1'b0, 1'b0, '0, '0);
    tick();
    drv0(1'b1, 1'b0, 7'h0C, '0);
    #1;
    chk("t6_rsp1v", bus.rsp1_valid, 1);
    chk("t6_rdata1", bus.rsp1_rdata, 32'h11111111);
    chk("t6_ready0", bus.req0_ready, 1);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    chk("t6_mr", bus.mem_read, 1);
    chk("t6_maddr", bus.mem_address, 32'h0C);
    tick();
    chk("t6_rsp0v", bus.rsp0_valid, 1);
    chk("t6_rdata0", bus.rsp0_rdata, 32'h22222222);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (posedge write, negedge read, word index address[6:2]).
- Requester 0 is the CPU load/store path. Requester 1 is the debug/loader port.
- Grants are round-robin, one access per two clocks. The block drives the memory control strobes and returns read data or a write acknowledge to the winner.
- Misaligned addresses are rejected without touching memory.

Parameters:
- ADDR_W, 7, byte address width passed to memory.
- DATA_W, 32, data word width.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a command.
- req0_write  input  1  1 = store, 0 = load.
- req0_addr  input  ADDR_W  byte address.
- req0_wdata  input  DATA_W  store data.
- req0_ready  output  1  command accepted this cycle (combinational grant in IDLE).
- rsp0_valid  output  1  one-cycle response pulse.
- rsp0_err  output  1  response is a misalignment error.
- rsp0_rdata  output  DATA_W  load data; updated only on a successful load.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_err, rsp1_rdata: same as requester 0, for requester 1.
- mem_address  output  ADDR_W  to memory address.
- mem_write  output  1  to MemWrite.
- mem_read  output  1  to MemRead.
- mem_wdata  output  DATA_W  to WriteData.
- mem_rdata  input  DATA_W  from ReadData.

Behaviour:
- Reset values (asynchronous, immediate): all outputs 0, state IDLE, last_grant = 1, so requester 0 wins the first tie.
- States: IDLE, ACCESS.

IDLE:
- reqN_ready is driven combinationally from the arbitration result. At most one ready is high. Ready is only ever high in IDLE.
- Only one valid high: grant that requester.
- Both valid: grant the requester that is not last_grant.
- Handshake completes at the posedge where valid && ready. On that edge the block latches write, addr, wdata and the grant id, and updates last_grant.
- addr[1:0] != 0: no memory access. Next cycle rspN_valid = 1 and rspN_err = 1; rsp_rdata holds its value; state stays IDLE.
- Aligned address: go to ACCESS.

ACCESS (exactly one cycle):
- mem_address, mem_wdata come from the latched registers. mem_write = latched write; mem_read = !latched write.
- Memory commits a store at the posedge ending ACCESS. A load's data appears at the mid-cycle negedge.
- At the posedge ending ACCESS:
  - a load captures mem_rdata into rspN_rdata;
  - rspN_valid pulses high for the following cycle, with rspN_err = 0;
  - state returns to IDLE.
- Outside ACCESS, mem_write = mem_read = 0. mem_address and mem_wdata hold their last values.

Throughput and ordering:
- The response cycle overlaps the next IDLE, so a new grant can occur in the same cycle as a response pulse.
- Sustained rate is 1 access per 2 clocks. Latency from handshake to rsp_valid is 2 posedges.
- Requesters must hold valid, write, addr and wdata stable until ready. Deasserting valid before ready drops the request with no side effect.
- Each requester has at most one outstanding command. This holds by construction, because ready is only asserted in IDLE.

Reset mid-ACCESS:
- mem_write and mem_read drop immediately, so the in-flight store does not commit.
- No response is issued. State goes to IDLE and last_grant goes to 1.

Test Plan:
- Reset, then req0 store addr 0x08 data 0xDEADBEEF, then req0 load 0x08 -> req0_ready on first IDLE; mem_write high for exactly 1 cycle; rsp0_valid pulses 2 cycles after each handshake; load returns rsp0_rdata = 0xDEADBEEF, rsp0_err = 0.
- Both valid continuously, each loading a distinct preloaded word (0x04 = 0x11111111, 0x0C = 0x22222222) -> grants alternate 0,1,0,1 starting with 0; one grant every 2 cycles; each rsp carries its own word.
- req1 load addr 0x05 (misaligned) -> mem_read and mem_write never assert; rsp1_valid = 1 and rsp1_err = 1 one cycle after handshake; rsp1_rdata unchanged.
- req0 store addr 0x10 data 0xA5A5A5A5, assert reset during ACCESS before the posedge -> mem_write falls immediately; a later load of 0x10 returns the prior contents, not 0xA5A5A5A5; no rsp0_valid.
- req0 valid for one IDLE cycle while req1 holds the grant, then req0 drops before ready -> no rsp0_valid, and memory is not accessed for req0.
- Back-to-back: req0 load issued in the same cycle as the rsp1_valid pulse -> grant accepted in that cycle; no idle bubble beyond the 2-cycle cadence.
